// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if -- bundle between the ID/forwarding side of the core
// and the ID/EX operand stage.
//   master : drives the decoded ID fields, MEM/WB forwarding sources and the
//            stall/flush controls; receives the EX-stage outputs.
//   slave  : the operand stage itself.
// ALU control encodings shared by the core are defined here as well.

`ifndef ALUCTRL_ADD
`define ALUCTRL_ADD 4'b0000
`endif
`ifndef ALUCTRL_SUB
`define ALUCTRL_SUB 4'b1000
`endif

interface ex_operand_stage_if #(
  parameter int XLEN = 32
);
  // ID stage fields
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_aluCtrl;
  logic            id_asel;
  logic            id_bsel;
  logic            id_regwen;
  logic            id_memread;
  logic            id_memwrite;
  // forwarding sources
  logic [4:0]      mem_rd;
  logic            mem_regwen;
  logic [XLEN-1:0] mem_aluout;
  logic [4:0]      wb_rd;
  logic            wb_regwen;
  logic [XLEN-1:0] wb_data;
  // pipeline control
  logic            stall_in;
  logic            flush;
  logic            hazard_stall;
  // EX stage outputs
  logic            ex_valid;
  logic            ex_regwen;
  logic            ex_memread;
  logic            ex_memwrite;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] aluin1;
  logic [XLEN-1:0] aluin2;
  logic [3:0]      aluCtrl;
  logic [XLEN-1:0] ex_store_data;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_aluCtrl, id_asel, id_bsel, id_regwen, id_memread,
           id_memwrite, mem_rd, mem_regwen, mem_aluout, wb_rd, wb_regwen,
           wb_data, stall_in, flush,
    input  hazard_stall, ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_pc,
           ex_rd, aluin1, aluin2, aluCtrl, ex_store_data
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_aluCtrl, id_asel, id_bsel, id_regwen, id_memread,
           id_memwrite, mem_rd, mem_regwen, mem_aluout, wb_rd, wb_regwen,
           wb_data, stall_in, flush,
    output hazard_stall, ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_pc,
           ex_rd, aluin1, aluin2, aluCtrl, ex_store_data
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage -- ID/EX pipeline register with operand forwarding and
// load-use hazard detection for the 5-stage RISC-V core.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : ex_operand_stage_if.slave (ID fields, MEM/WB forwarding sources,
//          stall_in/flush in; hazard_stall and EX operands/control out)

module ex_operand_stage #(
  parameter int         XLEN        = 32,
  parameter logic [3:0] NOP_ALUCTRL = `ALUCTRL_ADD
) (
  input logic               clk,
  input logic               rst,
  ex_operand_stage_if.slave bus
);

  logic            valid_p1;
  logic [XLEN-1:0] pc_p1;
  logic [4:0]      rs1_p1;
  logic [4:0]      rs2_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] rs1_val_p1;
  logic [XLEN-1:0] rs2_val_p1;
  logic [XLEN-1:0] imm_p1;
  logic [3:0]      alu_ctrl_p1;
  logic            asel_p1;
  logic            bsel_p1;
  logic            regwen_p1;
  logic            memread_p1;
  logic            memwrite_p1;

  logic            hazard;
  logic            kill;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // A producer matches a source register only when it writes and is not x0.
  function automatic logic reg_hit(input logic regwen, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return regwen && (rd != 5'd0) && (rd == rs);
  endfunction

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs,
                                              input logic [XLEN-1:0] val);
    if (reg_hit(bus.mem_regwen, bus.mem_rd, rs)) return bus.mem_aluout;
    if (reg_hit(bus.wb_regwen, bus.wb_rd, rs))   return bus.wb_data;
    return val;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = bus.id_valid && valid_p1 && memread_p1 && (rd_p1 != 5'd0) &&
             ((rd_p1 == bus.id_rs1) || (rd_p1 == bus.id_rs2)) && !bus.flush;
  end

  // Every case that loads an all-zero bubble; stall_in outranks the hazard
  // and empty-ID bubbles but not reset or flush.
  assign kill = rst || bus.flush ||
                (!bus.stall_in && (hazard || !bus.id_valid));

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (kill) begin
      valid_p1    <= 1'b0;
      pc_p1       <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_val_p1  <= '0;
      rs2_val_p1  <= '0;
      imm_p1      <= '0;
      alu_ctrl_p1 <= NOP_ALUCTRL;
      asel_p1     <= 1'b0;
      bsel_p1     <= 1'b0;
      regwen_p1   <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
    end else if (bus.stall_in) begin
      // The WB value would be gone by the time the hold releases, so latch it.
      if (reg_hit(bus.wb_regwen, bus.wb_rd, rs1_p1)) rs1_val_p1 <= bus.wb_data;
      if (reg_hit(bus.wb_regwen, bus.wb_rd, rs2_p1)) rs2_val_p1 <= bus.wb_data;
    end else begin
      valid_p1    <= 1'b1;
      pc_p1       <= bus.id_pc;
      rs1_p1      <= bus.id_rs1;
      rs2_p1      <= bus.id_rs2;
      rd_p1       <= bus.id_rd;
      // The regfile is not write-through: pick up a same-cycle WB write here.
      rs1_val_p1  <= reg_hit(bus.wb_regwen, bus.wb_rd, bus.id_rs1) ?
                     bus.wb_data : bus.id_rs1_data;
      rs2_val_p1  <= reg_hit(bus.wb_regwen, bus.wb_rd, bus.id_rs2) ?
                     bus.wb_data : bus.id_rs2_data;
      imm_p1      <= bus.id_imm;
      alu_ctrl_p1 <= bus.id_aluCtrl;
      asel_p1     <= bus.id_asel;
      bsel_p1     <= bus.id_bsel;
      regwen_p1   <= bus.id_regwen;
      memread_p1  <= bus.id_memread;
      memwrite_p1 <= bus.id_memwrite;
    end
  end

  // ---- EX operand selection ----
  assign fwd1 = fwd_sel(rs1_p1, rs1_val_p1);
  assign fwd2 = fwd_sel(rs2_p1, rs2_val_p1);

  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = valid_p1;
  assign bus.ex_regwen     = regwen_p1;
  assign bus.ex_memread    = memread_p1;
  assign bus.ex_memwrite   = memwrite_p1;
  assign bus.ex_pc         = pc_p1;
  assign bus.ex_rd         = rd_p1;
  assign bus.aluin1        = asel_p1 ? pc_p1 : fwd1;
  assign bus.aluin2        = bsel_p1 ? imm_p1 : fwd2;
  assign bus.aluCtrl       = alu_ctrl_p1;
  assign bus.ex_store_data = fwd2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage -- self-checking bench for ex_operand_stage: directed
// scenarios followed by randomized traffic against a behavioural model of the
// instruction sitting in EX.

`ifndef ALUCTRL_ADD
`define ALUCTRL_ADD 4'b0000
`endif
`ifndef ALUCTRL_SUB
`define ALUCTRL_SUB 4'b1000
`endif

module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(32)) bus ();

  ex_operand_stage #(.XLEN(32), .NOP_ALUCTRL(`ALUCTRL_ADD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of the instruction held in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic [3:0]  ctrl;
    logic        asel, bsel, regwen, memread, memwrite;
  } ex_t;

  ex_t m;
  bit  model_ok = 0;

  function automatic ex_t bubble();
    ex_t b = '0;
    b.ctrl = `ALUCTRL_ADD;
    return b;
  endfunction

  function automatic bit writes(input logic en, input logic [4:0] rd,
                                input logic [4:0] rs);
    return en && rd != 0 && rd == rs;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs,
                                          input logic [31:0] v);
    if (writes(bus.mem_regwen, bus.mem_rd, rs)) return bus.mem_aluout;
    if (writes(bus.wb_regwen, bus.wb_rd, rs))   return bus.wb_data;
    return v;
  endfunction

  function automatic bit exp_hazard();
    return bus.id_valid && m.valid && m.memread && m.rd != 0 &&
           (m.rd == bus.id_rs1 || m.rd == bus.id_rs2) && !bus.flush;
  endfunction

  task automatic check_model();
    logic [31:0] o1, o2;
    if (!model_ok) return;
    o1 = operand(m.rs1, m.v1);
    o2 = operand(m.rs2, m.v2);
    chk("hazard", 32'(bus.hazard_stall), 32'(exp_hazard()));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("ex_regwen", 32'(bus.ex_regwen), 32'(m.regwen));
    chk("ex_memread", 32'(bus.ex_memread), 32'(m.memread));
    chk("ex_memwrite", 32'(bus.ex_memwrite), 32'(m.memwrite));
    chk("aluCtrl", 32'(bus.aluCtrl), 32'(m.ctrl));
    if (m.valid) begin
      chk("ex_pc", bus.ex_pc, m.pc);
      chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
      chk("aluin1", bus.aluin1, m.asel ? m.pc : o1);
      chk("aluin2", bus.aluin2, m.bsel ? m.imm : o2);
      chk("store_data", bus.ex_store_data, o2);
    end
  endtask

  task automatic update_model();
    if (rst) begin
      m = bubble();
      model_ok = 1;
    end else if (bus.flush) begin
      m = bubble();
    end else if (bus.stall_in) begin
      if (writes(bus.wb_regwen, bus.wb_rd, m.rs1)) m.v1 = bus.wb_data;
      if (writes(bus.wb_regwen, bus.wb_rd, m.rs2)) m.v2 = bus.wb_data;
    end else if (exp_hazard() || !bus.id_valid) begin
      m = bubble();
    end else begin
      m.valid    = 1;
      m.pc       = bus.id_pc;
      m.rs1      = bus.id_rs1;
      m.rs2      = bus.id_rs2;
      m.rd       = bus.id_rd;
      m.v1       = writes(bus.wb_regwen, bus.wb_rd, bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
      m.v2       = writes(bus.wb_regwen, bus.wb_rd, bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;
      m.imm      = bus.id_imm;
      m.ctrl     = bus.id_aluCtrl;
      m.asel     = bus.id_asel;
      m.bsel     = bus.id_bsel;
      m.regwen   = bus.id_regwen;
      m.memread  = bus.id_memread;
      m.memwrite = bus.id_memwrite;
    end
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0;
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rd = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_aluCtrl = `ALUCTRL_ADD; bus.id_asel = 0; bus.id_bsel = 0;
    bus.id_regwen = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.mem_rd = 0; bus.mem_regwen = 0; bus.mem_aluout = 0;
    bus.wb_rd = 0; bus.wb_regwen = 0; bus.wb_data = 0;
    bus.stall_in = 0; bus.flush = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] ctrl,
                        input logic asel, input logic bsel, input logic regwen,
                        input logic memread, input logic memwrite);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rd = rd; bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_imm = imm; bus.id_aluCtrl = ctrl; bus.id_asel = asel;
    bus.id_bsel = bsel; bus.id_regwen = regwen; bus.id_memread = memread;
    bus.id_memwrite = memwrite;
  endtask

  initial begin
    idle();

    // Reset held two cycles with a live instruction in ID.
    rst = 1;
    set_id(32'h40, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h5, `ALUCTRL_SUB, 1, 1, 1, 1, 1);
    tick(); tick();
    idle();
    eval_cycle();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_regwen", 32'(bus.ex_regwen | bus.ex_memread | bus.ex_memwrite), 32'd0);
    chk("rst_pc", bus.ex_pc, 32'd0);
    chk("rst_aluin1", bus.aluin1, 32'd0);
    chk("rst_aluin2", bus.aluin2, 32'd0);
    chk("rst_aluCtrl", 32'(bus.aluCtrl), 32'(`ALUCTRL_ADD));
    tick();

    // add x5,x1,x2 then sub x6,x5,x3: MEM beats WB.
    set_id(32'h100, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 32'h0, `ALUCTRL_ADD, 0, 0, 1, 0, 0);
    eval_cycle(); tick();
    set_id(32'h104, 5'd5, 5'd3, 5'd6, 32'h0, 32'h7, 32'h0, `ALUCTRL_SUB, 0, 0, 1, 0, 0);
    eval_cycle(); tick();
    idle();
    bus.mem_rd = 5; bus.mem_regwen = 1; bus.mem_aluout = 32'h30;
    bus.wb_rd = 5; bus.wb_regwen = 1; bus.wb_data = 32'h11;
    eval_cycle();
    chk("memfwd_aluin1", bus.aluin1, 32'h30);
    chk("memfwd_aluCtrl", 32'(bus.aluCtrl), 32'(`ALUCTRL_SUB));
    chk("memfwd_aluin2", bus.aluin2, 32'h7);
    tick();

    // x0 is never forwarded.
    idle();
    set_id(32'h200, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h5, `ALUCTRL_ADD, 0, 1, 1, 0, 0);
    eval_cycle(); tick();
    idle();
    bus.mem_rd = 0; bus.mem_regwen = 1; bus.mem_aluout = 32'hDEADBEEF;
    bus.wb_rd = 0; bus.wb_regwen = 1; bus.wb_data = 32'hDEADBEEF;
    eval_cycle();
    chk("x0_aluin1", bus.aluin1, 32'h0);
    chk("x0_store", bus.ex_store_data, 32'h0);
    tick();

    // lw x7,0(x1) then addi x8,x7,4: one stall, bubble, then WB forward.
    idle();
    set_id(32'h300, 5'd1, 5'd0, 5'd7, 32'h100, 32'h0, 32'h0, `ALUCTRL_ADD, 0, 1, 1, 1, 0);
    eval_cycle(); tick();
    set_id(32'h304, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 32'h4, `ALUCTRL_ADD, 0, 1, 1, 0, 0);
    eval_cycle();
    chk("lu_hazard", 32'(bus.hazard_stall), 32'd1);
    tick();
    eval_cycle();
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_hazard_drop", 32'(bus.hazard_stall), 32'd0);
    tick();
    idle();
    bus.wb_rd = 7; bus.wb_regwen = 1; bus.wb_data = 32'h1234;
    eval_cycle();
    chk("lu_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_aluin1", bus.aluin1, 32'h1234);
    chk("lu_aluin2", bus.aluin2, 32'h4);
    tick();

    // Flush beats stall_in; flush also masks a load-use match.
    idle();
    set_id(32'h400, 5'd1, 5'd0, 5'd3, 32'h8, 32'h0, 32'h0, `ALUCTRL_ADD, 0, 1, 1, 1, 0);
    eval_cycle(); tick();
    set_id(32'h404, 5'd3, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, `ALUCTRL_ADD, 0, 0, 1, 0, 0);
    bus.flush = 1; bus.stall_in = 1;
    eval_cycle();
    chk("fl_hazard_masked", 32'(bus.hazard_stall), 32'd0);
    tick();
    bus.flush = 0; bus.stall_in = 0;
    eval_cycle();
    chk("fl_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_regwen", 32'(bus.ex_regwen), 32'd0);
    chk("fl_hazard", 32'(bus.hazard_stall), 32'd0);
    tick();

    // Stall refresh: sw with rs2=x9 holds while WB writes x9.
    idle();
    set_id(32'h500, 5'd1, 5'd9, 5'd0, 32'h200, 32'h0, 32'h8, `ALUCTRL_ADD, 0, 1, 0, 0, 1);
    eval_cycle(); tick();
    idle();
    bus.stall_in = 1;
    bus.wb_rd = 9; bus.wb_regwen = 1; bus.wb_data = 32'hCAFE;
    eval_cycle(); tick();
    bus.wb_rd = 0; bus.wb_regwen = 0; bus.wb_data = 0;
    eval_cycle(); tick();
    eval_cycle(); tick();
    bus.stall_in = 0;
    eval_cycle();
    chk("sr_valid", 32'(bus.ex_valid), 32'd1);
    chk("sr_store", bus.ex_store_data, 32'hCAFE);
    chk("sr_aluin2", bus.aluin2, 32'h8);
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_pc       = $urandom;
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_rd       = 5'($urandom_range(0, 3));
      bus.id_rs1_data = $urandom;
      bus.id_rs2_data = $urandom;
      bus.id_imm      = $urandom;
      bus.id_aluCtrl  = 4'($urandom);
      bus.id_asel     = 1'($urandom);
      bus.id_bsel     = 1'($urandom);
      bus.id_regwen   = 1'($urandom);
      bus.id_memread  = ($urandom_range(0, 2) == 0);
      bus.id_memwrite = 1'($urandom);
      bus.mem_rd      = 5'($urandom_range(0, 3));
      bus.mem_regwen  = 1'($urandom);
      bus.mem_aluout  = $urandom;
      bus.wb_rd       = 5'($urandom_range(0, 3));
      bus.wb_regwen   = 1'($urandom);
      bus.wb_data     = $urandom;
      bus.stall_in    = ($urandom_range(0, 5) == 0);
      bus.flush       = ($urandom_range(0, 7) == 0);
      eval_cycle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic for the 5-stage RISC-V core.
- Captures decoded instruction fields from ID and drives the EX-stage ALU operands (aluin1, aluin2) and ALU control (aluCtrl).
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, raises a stall to IF/ID and inserts a bubble into EX.

Parameters:
- XLEN, 32, datapath width.
- NOP_ALUCTRL, `ALUCTRL_ADD, aluCtrl value driven for bubbles and reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  instruction PC.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  32 each  regfile read data (regfile is not write-through).
- id_imm  in  32  sign-extended immediate.
- id_aluCtrl  in  4  ALU operation code.
- id_asel  in  1  0=rs1, 1=pc.
- id_bsel  in  1  0=rs2, 1=imm.
- id_regwen, id_memread, id_memwrite  in  1 each  control bits.
- mem_rd  in  5, mem_regwen  in  1, mem_aluout  in  32  EX/MEM forwarding source.
- wb_rd  in  5, wb_regwen  in  1, wb_data  in  32  WB forwarding source.
- stall_in  in  1  downstream hold.
- flush  in  1  kill instruction entering EX (branch/jump redirect).
- hazard_stall  out  1  load-use stall to PC/IF/ID.
- ex_valid, ex_regwen, ex_memread, ex_memwrite  out  1 each  registered control.
- ex_pc  out  32, ex_rd  out  5  registered fields.
- aluin1, aluin2  out  32  ALU operands.
- aluCtrl  out  4  ALU control.
- ex_store_data  out  32  forwarded rs2 value for stores.

Behaviour:
- Internal registers: valid, pc, rs1, rs2, rd, rs1_val, rs2_val, imm, aluCtrl, asel, bsel, regwen, memread, memwrite.
- Reset (synchronous): all registers 0, aluCtrl=NOP_ALUCTRL. All outputs therefore 0, except aluCtrl=NOP_ALUCTRL.
- Clock-edge update priority: rst > flush > stall_in > hazard_stall > normal load.
  - flush: load a bubble (valid, regwen, memread, memwrite = 0; aluCtrl=NOP_ALUCTRL; data fields 0). Takes precedence over stall_in.
  - stall_in: hold all registers, with one exception. If wb_regwen, wb_rd!=0 and wb_rd==rs1 (resp. rs2), overwrite rs1_val (resp. rs2_val) with wb_data. This prevents losing a value that retires during the hold.
  - hazard_stall (with no stall_in): load a bubble; ID holds its instruction externally.
  - normal: capture all id_* fields. Capture-time bypass: if wb_regwen, wb_rd!=0 and wb_rd==id_rs1 (resp. id_rs2), capture wb_data instead of the regfile data.
  - id_valid=0: capture as a bubble (control bits forced 0).
- hazard_stall is combinational and equals: id_valid & valid & memread & rd!=0 & (rd==id_rs1 | rd==id_rs2) & ~flush.
  - Asserted for exactly one cycle per load-use pair unless stall_in extends it.
- Forwarded rs1 value fwd1 (combinational):
  - mem_regwen & mem_rd!=0 & mem_rd==rs1 -> mem_aluout;
  - else wb_regwen & wb_rd!=0 & wb_rd==rs1 -> wb_data;
  - else rs1_val.
  - MEM has priority over WB. x0 is never forwarded.
- fwd2 uses the same rule on rs2.
- Operand and output selection:
  - aluin1 = asel ? pc : fwd1.
  - aluin2 = bsel ? imm : fwd2.
  - ex_store_data = fwd2 regardless of bsel.
  - aluCtrl = registered aluCtrl.
- Latency: one cycle from ID capture to valid operands at the ALU. Forwarding adds no cycles.
- Operands of bubbles are don't-care but must be deterministic (0 via the bubble fields).

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 -> all outputs 0 and aluCtrl=`ALUCTRL_ADD in the cycle after rst deasserts.
- MEM forward: `add x5,x1,x2` then `sub x6,x5,x3`, with mem_rd=5, mem_regwen=1, mem_aluout=0x00000030 and wb_rd=5, wb_data=0x11 -> aluin1=0x30 (MEM wins), aluCtrl=`ALUCTRL_SUB.
- x0 guard: mem_rd=0, mem_regwen=1, mem_aluout=0xDEADBEEF, instruction reads x0 with id_rs1_data=0 -> aluin1=0.
- Load-use: `lw x7,0(x1)` in EX, then ID `addi x8,x7,4` -> hazard_stall=1 for one cycle and a bubble (ex_valid=0) enters EX.
  - Next cycle the addi enters EX.
  - With wb_rd=7, wb_data=0x1234 now arriving, aluin1=0x1234 and aluin2=4.
- Flush beats stall: assert flush and stall_in together with a valid instruction in EX -> next cycle ex_valid=0, ex_regwen=0, hazard_stall=0.
- Stall refresh: hold with stall_in=1 for 3 cycles while WB writes x9=0xCAFE and the EX instruction reads rs2=x9 (store) -> after release ex_store_data=0xCAFE with no WB match present.
